// File: rtl/lsu_bus_bridge.sv
// Load/store bridge between the core and a valid/ready memory bus.
// Runs one bus transaction per access and holds the core in stall until it completes.
module lsu_bus_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  write_mem,
  input  logic [2:0]  read_mem,
  output logic [31:0] out_mem,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rdata
);

  // Handshake: a request is transferred on the rising edge where bus_req_valid and
  // bus_req_ready are both 1; address/data stay stable while valid is high. The bus
  // answers with a single-cycle bus_rsp_valid, never in the acceptance cycle itself.

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_W  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  state_t        state, state_nxt;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    ld_type_q;
  logic          ld_q;
  logic [1:0]    lane_q;

  logic          is_store, is_load, access, half_sz, word_sz, misalign, start;
  logic          timed_out, timeout_hit;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   rd_ext;

  // Store wins when both codes are set, so the load is not even considered.
  assign is_store = (write_mem != 2'b00);
  assign is_load  = !is_store && (read_mem >= LD_B) && (read_mem <= LD_HU);
  assign access   = is_store || is_load;
  assign half_sz  = is_store ? (write_mem == 2'b10) : (read_mem == LD_H || read_mem == LD_HU);
  assign word_sz  = is_store ? (write_mem == 2'b11) : (read_mem == LD_W);
  assign misalign = (half_sz && mem_addr[0]) || (word_sz && (mem_addr[1:0] != 2'b00));
  assign start    = (state == IDLE) && access && !misalign;

  // The counter value here counts completed REQ/WAIT cycles, so this cycle is the
  // TIMEOUT-th one when cnt+1 reaches the limit.
  assign timed_out = (TIMEOUT != 0) && (state == REQ || state == WAIT) &&
                     (int'(tmo_cnt) + 1 >= int'(TIMEOUT));
  assign timeout_hit = timed_out && !(state == WAIT && bus_rsp_valid);

  always_comb begin
    rd_byte = 8'h00;
    case (lane_q)
      2'd0: rd_byte = bus_rdata[7:0];
      2'd1: rd_byte = bus_rdata[15:8];
      2'd2: rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ld_type_q)
      LD_B:    rd_ext = {{24{rd_byte[7]}}, rd_byte};
      LD_H:    rd_ext = {{16{rd_half[15]}}, rd_half};
      LD_BU:   rd_ext = {24'h0, rd_byte};
      LD_HU:   rd_ext = {16'h0, rd_half};
      default: rd_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (timeout_hit)        state_nxt = DONE;
        else if (bus_req_ready) state_nxt = WAIT;
      end
      WAIT: if (bus_rsp_valid || timeout_hit) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall         = start || (state == REQ) || (state == WAIT);
    misaligned    = (state == IDLE) && access && misalign;
    bus_req_valid = (state == REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      out_mem   <= 32'h0;
      bus_err   <= 1'b0;
      bus_addr  <= 32'h0;
      bus_we    <= 1'b0;
      bus_wstrb <= 4'h0;
      bus_wdata <= 32'h0;
      ld_type_q <= 3'b000;
      ld_q      <= 1'b0;
      lane_q    <= 2'b00;
    end else begin
      bus_err <= timeout_hit;
      if (start) begin
        tmo_cnt   <= '0;
        bus_addr  <= {mem_addr[31:2], 2'b00};
        bus_we    <= is_store;
        ld_q      <= is_load;
        ld_type_q <= read_mem;
        lane_q    <= mem_addr[1:0];
        case (is_store ? write_mem : 2'b00)
          2'b01: begin
            bus_wstrb <= 4'b0001 << mem_addr[1:0];
            bus_wdata <= {4{mem_wdata[7:0]}};
          end
          2'b10: begin
            bus_wstrb <= 4'b0011 << {mem_addr[1], 1'b0};
            bus_wdata <= {2{mem_wdata[15:0]}};
          end
          2'b11: begin
            bus_wstrb <= 4'b1111;
            bus_wdata <= mem_wdata;
          end
          default: begin
            bus_wstrb <= 4'b0000;
            bus_wdata <= mem_wdata;
          end
        endcase
      end else if (state == REQ || state == WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (ld_q && state == WAIT && bus_rsp_valid) out_mem <= rd_ext;
      else if (ld_q && timeout_hit)               out_mem <= 32'h0;
    end
  end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: vector table of single accesses plus
// hand sequences for latency, timeout and mid-transaction reset.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, bus_rdata;
  logic [1:0]  write_mem;
  logic [2:0]  read_mem;
  logic        bus_req_ready, bus_rsp_valid;
  logic [31:0] out_mem, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_err, bus_req_valid, bus_we;
  logic [3:0]  bus_wstrb;

  int checks = 0;
  int errors = 0;

  lsu_bus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .write_mem(write_mem), .read_mem(read_mem), .out_mem(out_mem), .stall(stall),
    .misaligned(misaligned), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wm;
    logic [2:0]  rm;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_mis;
    logic        exp_req;
    logic [31:0] exp_out;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic        exp_we;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one access from just after a rising edge and plays the bus side:
  // ready after rdy_dly REQ cycles, response after rsp_dly WAIT cycles.
  task automatic run_access(input logic [1:0] wm, input logic [2:0] rm,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int rdy_dly, input int rsp_dly,
                            output int stalls, output int req_cyc, output logic err,
                            output logic mis, output logic stable,
                            output logic [31:0] a0, output logic [3:0] s0,
                            output logic [31:0] d0, output logic we0);
    logic pending;
    logic done;
    int   wcnt;
    write_mem = wm; read_mem = rm; mem_addr = a; mem_wdata = wd; bus_rdata = rd;
    stalls = 0; req_cyc = 0; err = 0; mis = 0; stable = 1; pending = 0; done = 0; wcnt = 0;
    a0 = 32'h0; s0 = 4'h0; d0 = 32'h0; we0 = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      bus_req_ready = 1'b0;
      bus_rsp_valid = 1'b0;
      if (misaligned) mis = 1'b1;
      if (bus_err) err = 1'b1;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stalls++;
        if (bus_req_valid) begin
          if (req_cyc == 0) begin
            a0 = bus_addr; s0 = bus_wstrb; d0 = bus_wdata; we0 = bus_we;
          end else if (bus_addr !== a0 || bus_wstrb !== s0 || bus_wdata !== d0 || bus_we !== we0) begin
            stable = 1'b0;
          end
          bus_req_ready = (req_cyc == rdy_dly);
          if (req_cyc == rdy_dly) pending = 1'b1;
          req_cyc++;
        end else if (pending) begin
          bus_rsp_valid = (wcnt == rsp_dly);
          wcnt++;
        end
      end
    end
    if (!done) begin
      errors++;
      $display("FAIL access_timeout: stall never dropped for addr %h", a);
    end
    @(posedge clk);
    #1;
    write_mem = 2'b00; read_mem = 3'b000; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
  endtask

  int          stalls, req_cyc;
  logic        err, mis, stable, we0;
  logic [31:0] a0, d0;
  logic [3:0]  s0;

  initial begin
    vecs[0]  = '{2'b00, 3'b011, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 4'b0000, 32'h0,        0};
    vecs[1]  = '{2'b00, 3'b001, 32'h103, 32'h0,        32'h80FF0000, 0, 1, 32'hFFFFFF80, 4'b0000, 32'h0,        0};
    vecs[2]  = '{2'b00, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 1, 32'h00000080, 4'b0000, 32'h0,        0};
    vecs[3]  = '{2'b10, 3'b000, 32'h102, 32'h1234ABCD, 32'h0,        0, 1, 32'h00000080, 4'b1100, 32'hABCDABCD, 1};
    vecs[4]  = '{2'b00, 3'b011, 32'h101, 32'h0,        32'h11111111, 1, 0, 32'h00000080, 4'b0000, 32'h0,        0};
    vecs[5]  = '{2'b00, 3'b010, 32'h202, 32'h0,        32'h80017FFF, 0, 1, 32'hFFFF8001, 4'b0000, 32'h0,        0};
    vecs[6]  = '{2'b00, 3'b101, 32'h200, 32'h0,        32'h8001F00D, 0, 1, 32'h0000F00D, 4'b0000, 32'h0,        0};
    vecs[7]  = '{2'b00, 3'b010, 32'h201, 32'h0,        32'h22222222, 1, 0, 32'h0000F00D, 4'b0000, 32'h0,        0};
    vecs[8]  = '{2'b01, 3'b000, 32'h301, 32'h000000A5, 32'h0,        0, 1, 32'h0000F00D, 4'b0010, 32'hA5A5A5A5, 1};
    vecs[9]  = '{2'b11, 3'b000, 32'h304, 32'hCAFEF00D, 32'h0,        0, 1, 32'h0000F00D, 4'b1111, 32'hCAFEF00D, 1};
    vecs[10] = '{2'b11, 3'b000, 32'h306, 32'h12345678, 32'h0,        1, 0, 32'h0000F00D, 4'b0000, 32'h0,        0};
    vecs[11] = '{2'b01, 3'b011, 32'h40B, 32'h00000011, 32'hFFFFFFFF, 0, 1, 32'h0000F00D, 4'b1000, 32'h11111111, 1};
    vecs[12] = '{2'b00, 3'b110, 32'h500, 32'h0,        32'h33333333, 0, 0, 32'h0000F00D, 4'b0000, 32'h0,        0};
    vecs[13] = '{2'b00, 3'b001, 32'h000, 32'h0,        32'h0000007F, 0, 1, 32'h0000007F, 4'b0000, 32'h0,        0};
    vecs[14] = '{2'b10, 3'b000, 32'h0FF, 32'h0000BEEF, 32'h0,        1, 0, 32'h0000007F, 4'b0000, 32'h0,        0};

    rst = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; write_mem = 2'b00; read_mem = 3'b000;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_mem", out_mem, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_req_valid", {31'h0, bus_req_valid}, 32'h0);
    chk("rst_flags", {29'h0, misaligned, bus_err, bus_we}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      run_access(vecs[i].wm, vecs[i].rm, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, 0, 0,
                 stalls, req_cyc, err, mis, stable, a0, s0, d0, we0);
      chk($sformatf("v%0d_misaligned", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      chk($sformatf("v%0d_stalls", i), stalls, vecs[i].exp_req ? 3 : 0);
      chk($sformatf("v%0d_req_cycles", i), req_cyc, vecs[i].exp_req ? 1 : 0);
      chk($sformatf("v%0d_bus_err", i), {31'h0, err}, 32'h0);
      @(negedge clk);
      chk($sformatf("v%0d_out_mem", i), out_mem, vecs[i].exp_out);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d_bus_addr", i), a0, vecs[i].addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_wstrb", i), {28'h0, s0}, {28'h0, vecs[i].exp_wstrb});
        chk($sformatf("v%0d_we", i), {31'h0, we0}, {31'h0, vecs[i].exp_we});
        if (vecs[i].exp_we) chk($sformatf("v%0d_wdata", i), d0, vecs[i].exp_wdata);
      end
      @(posedge clk);
      #1;
    end

    // Slow ready: two REQ cycles plus one WAIT cycle stays under the limit of 4.
    run_access(2'b00, 3'b011, 32'h700, 32'h0, 32'h0BADF00D, 1, 0,
               stalls, req_cyc, err, mis, stable, a0, s0, d0, we0);
    chk("slow_stalls", stalls, 4);
    chk("slow_req_cycles", req_cyc, 2);
    chk("slow_stable", {31'h0, stable}, 32'h1);
    chk("slow_err", {31'h0, err}, 32'h0);
    chk("slow_out_mem", out_mem, 32'h0BADF00D);

    // Ready never comes: four REQ cycles then DONE with bus_err; a store leaves out_mem alone.
    run_access(2'b11, 3'b000, 32'h900, 32'h5A5A5A5A, 32'h0, 100, 0,
               stalls, req_cyc, err, mis, stable, a0, s0, d0, we0);
    chk("tmo_req_stalls", stalls, 5);
    chk("tmo_req_cycles", req_cyc, 4);
    chk("tmo_req_stable", {31'h0, stable}, 32'h1);
    chk("tmo_req_err", {31'h0, err}, 32'h1);
    chk("tmo_req_out_mem", out_mem, 32'h0BADF00D);
    @(negedge clk);
    chk("tmo_err_pulse_end", {31'h0, bus_err}, 32'h0);
    @(posedge clk);
    #1;

    // Accepted but never answered: one REQ plus three WAIT cycles, load result forced to 0.
    run_access(2'b00, 3'b011, 32'h800, 32'h0, 32'hFFFFFFFF, 0, 100,
               stalls, req_cyc, err, mis, stable, a0, s0, d0, we0);
    chk("tmo_wait_stalls", stalls, 5);
    chk("tmo_wait_req_cycles", req_cyc, 1);
    chk("tmo_wait_err", {31'h0, err}, 32'h1);
    chk("tmo_wait_out_mem", out_mem, 32'h0);

    // Refill out_mem, then reset in WAIT with a late response on the following cycle.
    run_access(2'b00, 3'b011, 32'hA00, 32'h0, 32'h600DCAFE, 0, 0,
               stalls, req_cyc, err, mis, stable, a0, s0, d0, we0);
    chk("pre_rst_out_mem", out_mem, 32'h600DCAFE);
    write_mem = 2'b00; read_mem = 3'b011; mem_addr = 32'hB00; bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("midrst_idle_stall", {31'h0, stall}, 32'h1);
    @(negedge clk);
    chk("midrst_req_valid", {31'h0, bus_req_valid}, 32'h1);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    chk("midrst_wait_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1; read_mem = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    bus_rsp_valid = 1'b1;
    chk("midrst_stall", {31'h0, stall}, 32'h0);
    chk("midrst_req_valid_low", {31'h0, bus_req_valid}, 32'h0);
    chk("midrst_out_mem", out_mem, 32'h0);
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    chk("late_rsp_out_mem", out_mem, 32'h0);
    chk("late_rsp_stall", {31'h0, stall}, 32'h0);
    chk("late_rsp_err", {31'h0, bus_err}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
